// File: rtl/cle_pkg.sv
// Shared constants, FSM state type and the ROM byte unpacking helper for the
// connected-component labeling engine.
package cle_pkg;

  localparam int IMG_W  = 32;
  localparam int NPIX   = IMG_W * IMG_W;
  localparam int ROM_AW = 7;
  localparam int RAM_AW = 10;

  typedef enum logic [2:0] {
    LOAD,
    SEED,
    GROW,
    WRITE,
    DONE
  } cle_state_t;

  // ROM bytes store the leftmost pixel in bit 7, while the image register
  // keeps pixel (row, col) at bit row*32+col. This reverses the bit order so
  // a byte drops straight into an 8-bit slice of the image register.
  function automatic logic [7:0] rom_byte_to_pixels(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/cle_dilate8.sv
// Combinational 8-neighbour dilation of a 32x32 pixel mask.
// Bit row*32+col is pixel (row, col); pixels outside the image are background.
module cle_dilate8
  import cle_pkg::*;
(
  input  logic [NPIX-1:0] mask,
  output logic [NPIX-1:0] dilated
);

  // Column 0 and column 31 of every row; used to stop horizontal shifts from
  // wrapping a pixel onto the opposite edge of the neighbouring row.
  localparam logic [NPIX-1:0] COL0  = {IMG_W{32'h0000_0001}};
  localparam logic [NPIX-1:0] COL31 = {IMG_W{32'h8000_0000}};

  logic [NPIX-1:0] horiz;

  // Spread horizontally first, then vertically; the two-step spread covers
  // the four diagonal neighbours as well as the orthogonal ones.
  always_comb begin
    horiz   = mask | ((mask << 1) & ~COL0) | ((mask >> 1) & ~COL31);
    dilated = horiz | (horiz << IMG_W) | (horiz >> IMG_W);
  end

endmodule

// File: rtl/cle_engine.sv
// Connected-component labeling engine: loads a 32x32 binary image from ROM,
// clears the label SRAM, then repeatedly seeds, grows and writes out one
// 8-connected component at a time until no foreground pixels remain.
module cle_engine
  import cle_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rom_q,
  output logic [ROM_AW-1:0] rom_a,
  output logic [RAM_AW-1:0] sram_a,
  output logic [7:0]        sram_d,
  output logic              sram_wen,
  output logic              finish
);

  cle_state_t        state;
  cle_state_t        next_state;

  logic [RAM_AW-1:0] cnt;
  logic              cap_valid;
  logic [ROM_AW-1:0] cap_addr;
  logic [7:0]        comp_cnt;

  logic [NPIX-1:0]   remaining;
  logic [NPIX-1:0]   mask;
  logic [NPIX-1:0]   dilated;
  logic [NPIX-1:0]   grown;
  logic [NPIX-1:0]   seed_mask;

  cle_dilate8 u_dilate (
    .mask    (mask),
    .dilated (dilated)
  );

  // Isolate the lowest set bit of the unlabeled pixels (two's-complement
  // trick) as the next seed, and clip the dilated mask to unlabeled pixels.
  always_comb begin
    seed_mask = remaining & (~remaining + {{(NPIX-1){1'b0}}, 1'b1});
    grown     = dilated & remaining;
  end

  // State register; an asynchronous reset always restarts from LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic for the load / seed / grow / write / done sequence.
  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (&cnt) next_state = SEED;
      SEED:    next_state = (remaining == '0) ? DONE : GROW;
      GROW:    if (grown == mask) next_state = WRITE;
      WRITE:   if (&cnt) next_state = SEED;
      DONE:    next_state = DONE;
      default: next_state = LOAD;
    endcase
  end

  // ROM address issue and capture. ROM data returns one edge after the
  // address is sampled, so the sampled address is delayed one stage to
  // place each returned byte into the image register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_a     <= '0;
      cap_valid <= 1'b0;
      cap_addr  <= '0;
    end else begin
      cap_valid <= (state == LOAD) && (cnt < 10'd128);
      cap_addr  <= rom_a;
      if ((state == LOAD) && (cnt < 10'd127)) begin
        rom_a <= rom_a + 1'b1;
      end
    end
  end

  // Image/mask registers, the shared scan counter, the component counter and
  // the registered SRAM write port. The write port defaults to idle each
  // cycle, so a write strobe lasts exactly one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      comp_cnt  <= '0;
      remaining <= '0;
      mask      <= '0;
      sram_a    <= '0;
      sram_d    <= '0;
      sram_wen  <= 1'b1;
      finish    <= 1'b0;
    end else begin
      sram_wen <= 1'b1;
      if (cap_valid) begin
        remaining[{cap_addr, 3'b000} +: 8] <= rom_byte_to_pixels(rom_q);
      end
      case (state)
        LOAD: begin
          cnt      <= cnt + 1'b1;
          sram_a   <= cnt;
          sram_d   <= '0;
          sram_wen <= 1'b0;
        end
        SEED: begin
          cnt  <= '0;
          mask <= seed_mask;
        end
        GROW: begin
          cnt  <= '0;
          mask <= grown;
        end
        WRITE: begin
          cnt      <= cnt + 1'b1;
          sram_a   <= cnt;
          sram_d   <= comp_cnt + 8'd1;
          sram_wen <= ~mask[cnt];
          if (&cnt) begin
            remaining <= remaining & ~mask;
            comp_cnt  <= comp_cnt + 8'd1;
          end
        end
        DONE: begin
          cnt    <= '0;
          finish <= 1'b1;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cle_engine.sv
// Self-checking bench for cle_engine with behavioural ROM and SRAM models.
module tb_cle_engine;

  logic       clk;
  logic       reset;
  logic [7:0] rom_q;
  logic [6:0] rom_a;
  logic [9:0] sram_a;
  logic [7:0] sram_d;
  logic       sram_wen;
  logic       finish;

  logic [7:0] rom     [128];
  logic [7:0] sram    [1024];
  logic [7:0] expImg  [1024];
  int         nzWrites [1024];
  int         xCount;
  int         writesAfterFinish;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int         scen;
    int         addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  cle_engine dut (
    .clk      (clk),
    .reset    (reset),
    .rom_q    (rom_q),
    .rom_a    (rom_a),
    .sram_a   (sram_a),
    .sram_d   (sram_d),
    .sram_wen (sram_wen),
    .finish   (finish)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM: data for the sampled address appears after the edge.
  always @(posedge clk) rom_q <= rom[rom_a];

  // Synchronous SRAM plus write statistics; stats and contents are
  // re-initialised while reset is held so each run starts fresh.
  always @(posedge clk) begin
    if (!reset) begin
      xCount = 0;
      writesAfterFinish = 0;
      for (int i = 0; i < 1024; i++) begin
        sram[i] <= 8'hAA;
        nzWrites[i] = 0;
      end
    end else if (sram_wen === 1'b0) begin
      if ($isunknown(sram_a) || $isunknown(sram_d)) begin
        xCount++;
      end else begin
        sram[sram_a] <= sram_d;
        if (sram_d != 8'd0) nzWrites[sram_a]++;
        if (finish) writesAfterFinish++;
      end
    end else if (sram_wen !== 1'b1) begin
      xCount++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setPix(input int row, input int col, input logic [7:0] label);
    int idx;
    idx = row * 4 + col / 8;
    rom[idx] = rom[idx] | 8'(8'h80 >> (col % 8));
    expImg[row * 32 + col] = label;
  endtask

  task automatic applyStimulus(input int scen);
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    for (int p = 0; p < 1024; p++) expImg[p] = 8'h00;
    case (scen)
      1: begin
        for (int i = 0; i < 128; i++) rom[i] = 8'hFF;
        for (int p = 0; p < 1024; p++) expImg[p] = 8'h01;
      end
      2: begin
        setPix(0, 0, 8'd1);
        setPix(1, 1, 8'd1);
        setPix(2, 2, 8'd1);
      end
      3: begin
        setPix(0, 31, 8'd1);
        setPix(1, 0, 8'd2);
      end
      4: begin
        for (int k = 0; k < 27; k++) begin
          for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
              setPix(4 * (k / 8) + dr, 4 * (k % 8) + dc, 8'(k + 1));
            end
          end
        end
      end
      5: begin
        setPix(0, 0, 8'd1);
        setPix(0, 4, 8'd1);
        setPix(1, 1, 8'd1);
        setPix(1, 3, 8'd1);
        setPix(2, 2, 8'd1);
        setPix(0, 10, 8'd2);
        setPix(3, 20, 8'd3);
        setPix(4, 19, 8'd3);
        setPix(5, 18, 8'd3);
        setPix(4, 5, 8'd4);
      end
      default: ;
    endcase
  endtask

  task automatic runToFinish(input string name);
    int cyc;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (finish !== 1'b1 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({name, "_finish_rise"}, {31'd0, finish}, 32'd1);
    repeat (20) @(negedge clk);
    checkOutput({name, "_finish_held"}, {31'd0, finish}, 32'd1);
  endtask

  task automatic checkImage(input string name, input int scen);
    int bad;
    int firstBad;
    int multi;
    bad = 0;
    firstBad = -1;
    multi = 0;
    for (int p = 0; p < 1024; p++) begin
      if (sram[p] !== expImg[p]) begin
        if (firstBad < 0) firstBad = p;
        bad++;
      end
      if (nzWrites[p] > 1) multi++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("[TB] FAIL %s_image: %0d bad bytes, first at %0d got 0x%0h expected 0x%0h",
               name, bad, firstBad, sram[firstBad], expImg[firstBad]);
    end
    checkOutput({name, "_multi_nz_write"}, multi, 0);
    checkOutput({name, "_x_on_write"}, xCount, 0);
    checkOutput({name, "_write_after_finish"}, writesAfterFinish, 0);
    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].scen == scen) begin
        checkOutput($sformatf("%s_addr%0d", name, vecs[v].addr), {24'd0, sram[vecs[v].addr]}, {24'd0, vecs[v].exp});
      end
    end
  endtask

  function automatic vec_t mkVec(input int scen, input int addr, input logic [7:0] exp);
    vec_t v;
    v.scen = scen;
    v.addr = addr;
    v.exp  = exp;
    return v;
  endfunction

  initial begin
    vecs.push_back(mkVec(0, 0, 8'h00));
    vecs.push_back(mkVec(0, 1023, 8'h00));
    vecs.push_back(mkVec(1, 0, 8'h01));
    vecs.push_back(mkVec(1, 527, 8'h01));
    vecs.push_back(mkVec(1, 1023, 8'h01));
    vecs.push_back(mkVec(2, 0, 8'h01));
    vecs.push_back(mkVec(2, 33, 8'h01));
    vecs.push_back(mkVec(2, 66, 8'h01));
    vecs.push_back(mkVec(2, 1, 8'h00));
    vecs.push_back(mkVec(2, 34, 8'h00));
    vecs.push_back(mkVec(3, 31, 8'h01));
    vecs.push_back(mkVec(3, 32, 8'h02));
    vecs.push_back(mkVec(3, 0, 8'h00));
    vecs.push_back(mkVec(4, 0, 8'h01));
    vecs.push_back(mkVec(4, 33, 8'h01));
    vecs.push_back(mkVec(4, 28, 8'h08));
    vecs.push_back(mkVec(4, 128, 8'h09));
    vecs.push_back(mkVec(4, 384, 8'h19));
    vecs.push_back(mkVec(4, 392, 8'h1B));
    vecs.push_back(mkVec(4, 425, 8'h1B));
    vecs.push_back(mkVec(4, 394, 8'h00));
    vecs.push_back(mkVec(4, 396, 8'h00));
    vecs.push_back(mkVec(5, 0, 8'h01));
    vecs.push_back(mkVec(5, 35, 8'h01));
    vecs.push_back(mkVec(5, 66, 8'h01));
    vecs.push_back(mkVec(5, 34, 8'h00));
    vecs.push_back(mkVec(5, 10, 8'h02));
    vecs.push_back(mkVec(5, 116, 8'h03));
    vecs.push_back(mkVec(5, 147, 8'h03));
    vecs.push_back(mkVec(5, 178, 8'h03));
    vecs.push_back(mkVec(5, 133, 8'h04));

    reset = 1'b0;
    applyStimulus(0);
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", {5'd0, rom_a, sram_a, sram_d, sram_wen, finish}, {5'd0, 7'd0, 10'd0, 8'd0, 1'b1, 1'b0});

    for (int s = 0; s <= 5; s++) begin
      string nm;
      nm = $sformatf("scen%0d", s);
      applyStimulus(s);
      runToFinish(nm);
      checkImage(nm, s);
    end

    // Abort a run partway through component growth and restart it.
    applyStimulus(1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (1035) @(negedge clk);
    checkOutput("midrun_not_finished", {31'd0, finish}, 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checkOutput("midrun_reset_outputs", {5'd0, rom_a, sram_a, sram_d, sram_wen, finish}, {5'd0, 7'd0, 10'd0, 8'd0, 1'b1, 1'b0});
    runToFinish("rerun");
    checkImage("rerun", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cle_engine.md
Name: cle_engine

Overview:
- Connected-component labeling engine for a 32x32 binary image.
- Reads the image from an external 128x8 synchronous ROM (rom_128x8) and writes one 8-bit label per pixel to an external 1024x8 synchronous SRAM (sram_1024x8).
- Background pixels get label 0. Each 8-connected foreground component gets a unique nonzero label.
- Asserts finish when the SRAM image is complete. The block has no SRAM read path; all state is held internally.

Parameters:
- IMG_W, 32, image width/height in pixels (fixed; no other value supported)
- ROM_AW, 7, ROM address width (128 bytes = 1024 pixels)
- RAM_AW, 10, SRAM address width (one byte per pixel)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- rom_q  in  8  ROM read data; valid one cycle after rom_a is presented
- rom_a  out  7  ROM byte address
- sram_a  out  10  SRAM address = row*32 + col
- sram_d  out  8  SRAM write data (label)
- sram_wen  out  1  SRAM write enable, active low; write occurs at the rising edge while low
- finish  out  1  high when labeling is complete

Behaviour:
- Reset (reset=0, async) values: rom_a=0, sram_a=0, sram_d=0, sram_wen=1, finish=0, all internal state cleared.
- Reset asserted mid-operation aborts immediately. The next release restarts from LOAD.
- Image mapping: ROM byte r holds row r/4, columns (r%4)*8 .. (r%4)*8+7. Bit 7 (MSB) is the leftmost pixel. 1 = foreground.
- Connectivity: 8-neighbour (orthogonal and diagonal). Pixels outside the 32x32 border are background.
- Label numbering: components are numbered 1,2,3,... in raster order of each component's first pixel (smallest row*32+col). Maximum is 255 components.

State machine:
- LOAD: issue rom_a=0..127 on consecutive cycles. Capture rom_q one cycle later into a 1024-bit image register. 129 cycles total. In parallel, write 0 to all SRAM addresses (sram_wen=0, sram_d=0), one per cycle. CLEAR continues until all 1024 addresses are written.
- SEED: find the lowest-index set bit of the remaining-image register.
  - If none, go to DONE.
  - Otherwise mask = that single bit; go to GROW.
- GROW: each cycle, next_mask = dilate8(mask) & remaining.
  - If next_mask == mask, go to WRITE.
  - Otherwise update mask and stay in GROW.
- WRITE: scan addresses 0..1023. For each address whose mask bit is set, drive sram_a=addr, sram_d=label, sram_wen=0; all other cycles keep sram_wen=1. At the end: remaining &= ~mask, label++, go to SEED.
- DONE: sram_wen=1; finish=1 and held until reset. finish rises only after the final SRAM write edge has occurred.
- No SRAM address is written with a nonzero value more than once. Every address is written at least once (0 in LOAD), so no X remains.
- sram_d and sram_a never carry X while sram_wen=0.

Decomposition:
- Package cle_pkg: IMG_W, NPIX=1024, ROM_AW, RAM_AW, and the state enum {LOAD, SEED, GROW, WRITE, DONE}.
- Sub-module cle_dilate8: combinational. Input: 1024-bit mask. Output: OR of the mask and its 8 neighbour shifts, with row-border masking (no wrap from column 31 to column 0).
- The top module holds the FSM, counters, label register, and the image/mask registers.

Test Plan:
- All-zero ROM -> all 1024 SRAM bytes = 0x00; finish rises; no nonzero write.
- All-0xFF ROM -> every SRAM byte = 0x01; exactly one component.
- Pixels (0,0), (1,1), (2,2) only (ROM bytes 0x80 at addr 0, 0x40 at addr 4, 0x20 at addr 8) -> SRAM[0], SRAM[33], SRAM[66] = 0x01, all others 0. Confirms diagonal connectivity.
- Pixels (0,31) and (1,0) (ROM addr 3=0x01, addr 4=0x80) -> two components: SRAM[31]=0x01, SRAM[32]=0x02. Confirms no row wrap.
- Image with 27 separated blobs -> 27 distinct labels 1..27 in raster order of first pixel; background 0; finish held high.
- Assert reset low during GROW, then release -> outputs return to reset values immediately; the full run then repeats with identical final SRAM contents.
